// File: rtl/message_pkg.sv
// -----------------------------------------------------------------------------
// message_pkg
// Shared constants and types for the message region: geometry of the region
// (also used by the draw-side coordinate counter), frame-buffer widths, the
// reader FSM state type and the {x, y, colour} pixel tuple.
// -----------------------------------------------------------------------------
package message_pkg;

   localparam int X_MAX    = 160;   // last column index (inclusive)
   localparam int Y_MAX    = 30;    // last row index (inclusive)
   localparam int COLOUR_W = 3;
   localparam int ADDR_W   = 13;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int PIX_W    = X_W + Y_W + COLOUR_W;

   localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// -----------------------------------------------------------------------------
// pixel_skid_fifo
// Two-entry FIFO holding packed pixel tuples between the RAM read port and the
// downstream consumer. The head entry is always visible on head_o.
// Ports:
//   clock_i, reset_i : clock, asynchronous active-high reset
//   push_i, data_i   : write one entry (never asserted while full)
//   pop_i            : remove head entry (never asserted while empty)
//   head_o           : current head entry
//   occ_o            : occupancy 0..2
//   full_o, empty_o  : occupancy flags
// -----------------------------------------------------------------------------
module pixel_skid_fifo
   import message_pkg::*;
(
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [PIX_W-1:0] data_i,
   input  logic             pop_i,
   output logic [PIX_W-1:0] head_o,
   output logic [1:0]       occ_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PIX_W-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push_i;
      rd_ptr_d = rd_ptr_q ^ pop_i;
      count_d  = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + 2'd1;
      end else if (!push_i && pop_i) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign occ_o   = count_q;
   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/message_region_reader.sv
// -----------------------------------------------------------------------------
// message_region_reader
// Sweeps the message region (x fastest, row-major) out of the frame-buffer RAM
// and streams (x, y, colour) tuples downstream.
// Handshake: a pixel transfers on any rising edge where out_valid_o and
// out_ready_i are both high; out_valid_o never depends on out_ready_i, and the
// out_* data hold steady while out_valid_o=1 and out_ready_i=0.
// Ports:
//   clock_i, reset_i   : clock, asynchronous active-high reset
//   start_i            : begin one sweep (only honoured in IDLE)
//   busy_o, done_o     : sweep in progress / one-cycle completion pulse
//   rd_en_o, rd_addr_o : RAM read strobe and address
//   rd_data_i          : RAM data, one cycle after rd_en_o
//   out_*              : presented pixel and its valid/ready handshake
//   dbg_state_o        : FSM state for observation
// -----------------------------------------------------------------------------
module message_region_reader
   import message_pkg::*;
(
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                start_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                rd_en_o,
   output logic [ADDR_W-1:0]   rd_addr_o,
   input  logic [COLOUR_W-1:0] rd_data_i,
   output logic [X_W-1:0]      out_x_o,
   output logic [Y_W-1:0]      out_y_o,
   output logic [COLOUR_W-1:0] out_colour_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [1:0]          dbg_state_o
);

   state_e            state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [X_W-1:0]    tag_x_q, tag_x_d;
   logic [Y_W-1:0]    tag_y_q, tag_y_d;
   logic              inflight_q, inflight_d;

   logic [1:0]        fifo_occ;
   logic              fifo_full, fifo_empty;
   logic [PIX_W-1:0]  fifo_head;
   pixel_t            push_pix, head_pix;
   logic              pop, issue;

   assign pop = out_valid_o & out_ready_i;

   // Entries already held or still in flight, less the one leaving this
   // cycle, must leave room for the new read when it lands next cycle.
   assign issue = (state_q == RUN) &&
                  (({1'b0, fifo_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      addr_d     = addr_q;
      tag_x_d    = tag_x_q;
      tag_y_d    = tag_y_q;
      inflight_d = issue;

      if (issue) begin
         tag_x_d = x_q;
         tag_y_d = y_q;
         addr_d  = addr_q + ADDR_W'(1);
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               x_d     = '0;
               y_d     = '0;
               addr_d  = '0;
            end
         end
         RUN: begin
            if (issue && (x_q == X_LAST) && (y_q == Y_LAST)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as soon as the buffer will be empty after this edge, so
            // done lands the cycle right after the last handshake.
            if (!inflight_q && (fifo_empty || (!fifo_full && pop))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         addr_q     <= '0;
         tag_x_q    <= '0;
         tag_y_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         addr_q     <= addr_d;
         tag_x_q    <= tag_x_d;
         tag_y_q    <= tag_y_d;
         inflight_q <= inflight_d;
      end
   end

   assign push_pix = {tag_x_q, tag_y_q, rd_data_i};

   pixel_skid_fifo u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (inflight_q),
      .data_i  (push_pix),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .occ_o   (fifo_occ),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_pix     = fifo_head;
   assign out_x_o      = head_pix.x;
   assign out_y_o      = head_pix.y;
   assign out_colour_o = head_pix.colour;
   assign out_valid_o  = !fifo_empty;

   assign rd_en_o     = issue;
   assign rd_addr_o   = addr_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign dbg_state_o = state_q;

endmodule
